mean_filter: RTL and testbench

- Parametrised 3x3 box (mean) filter for the DVP video-processing chain; supplies the mean path selected by mode 2'b11 in the filter selector.
- Processes CHANNELS independent colour channels of DW bits each (default 3x8 = 24-bit RGB/YCbCr) on the pixel-clock stream.
- Uses internal line buffers and a frame-synchronous enable, so a frame is never half-filtered.
- Bypass path has the same latency as the filter path, so downstream timing is identical in both modes.

---
 rtl/mean_filter.sv | 242 ++++++++++++++++++++++++
 tb/tb_mean_filter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mean_filter.sv
// Purpose : 3x3 box (mean) filter over CHANNELS x DW-bit pixels, line-buffered, frame-synchronous enable.
// Latency : fixed 3 clk from per_* to post_*, identical for filtered and bypassed pixels.
// Backpres: none; free-running pixel stream, every per_de pixel yields exactly one post_de pixel.
//
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   en                  filter enable request, taken only on the per_vs rising edge
//   per_vs/de/data      input sync, data enable and packed pixel (channel k at [k*DW +: DW])
//   post_vs/de/data     outputs delayed 3 clk; post_data holds while post_de is low
//
// Optional feature: define MEAN_FILTER_ROUND_EN for round-to-nearest (sum+4)/9;
// by default the mean truncates (sum/9). Latency is the same either way.
module mean_filter #(
   parameter int IMG_HDISP = 1280,
   parameter int IMG_VDISP = 720,
   parameter int DW        = 8,
   parameter int CHANNELS  = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   per_vs,
   input  logic                   per_de,
   input  logic [CHANNELS*DW-1:0] per_data,
   output logic                   post_vs,
   output logic                   post_de,
   output logic [CHANNELS*DW-1:0] post_data
);

   localparam int PW  = CHANNELS * DW;
   localparam int AW  = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
   localparam int CW  = $clog2(IMG_HDISP + 1);
   localparam int RW  = $clog2(IMG_VDISP + 1);
   localparam int RSW = DW + 2;   // sum of 3 samples
   localparam int SW  = DW + 4;   // sum of 9 samples, 9*(2^DW-1) < 2^(DW+4)
`ifdef MEAN_FILTER_ROUND_EN
   localparam int RND = 4;
`else
   localparam int RND = 0;
`endif

   // ------------------------------------------------------------------
   // Edge detection. vs_d resets high so that a reset released in the
   // middle of a frame (per_vs still high) is not mistaken for a frame
   // start; the filter then stays in bypass until a genuine rising edge.
   // ------------------------------------------------------------------
   logic vs_d, de_d;
   logic vs_rise, de_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_d <= 1'b1;
         de_d <= 1'b0;
      end else begin
         vs_d <= per_vs;
         de_d <= per_de;
      end
   end

   assign vs_rise = per_vs & ~vs_d;
   assign de_fall = de_d & ~per_de;

   // ------------------------------------------------------------------
   // Position counters and frame enable. On a frame-start cycle the
   // pixel is treated as (0,0) with the freshly sampled enable, hence
   // the *_eff views used by the datapath.
   // ------------------------------------------------------------------
   logic [CW-1:0] col, col_eff;
   logic [RW-1:0] row, row_eff;
   logic          frame_en, fen_eff;
   logic          in_line;

   assign col_eff = vs_rise ? '0 : col;
   assign row_eff = vs_rise ? '0 : row;
   assign fen_eff = vs_rise ? en : frame_en;
   assign in_line = per_de && (col_eff < CW'(IMG_HDISP));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col      <= '0;
         row      <= '0;
         frame_en <= 1'b0;
      end else begin
         if (vs_rise)
            frame_en <= en;

         if (per_de) begin
            if (in_line)
               col <= col_eff + CW'(1);
            else
               col <= col_eff;        // saturated at IMG_HDISP
         end else if (de_fall || vs_rise) begin
            col <= '0;
         end

         if (vs_rise)
            row <= '0;
         else if (de_fall && (row < RW'(IMG_VDISP)))
            row <= row + RW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Line buffers: lb0 holds the previous row, lb1 the one before.
   // Read is combinational so the window can be captured in the same
   // cycle the pixel arrives. Contents are not reset; rows above the
   // frame are never read because row_eff selects clamped samples.
   // ------------------------------------------------------------------
   logic [PW-1:0] lb0 [IMG_HDISP];
   logic [PW-1:0] lb1 [IMG_HDISP];
   logic [AW-1:0] lb_addr;
   logic [PW-1:0] lb0_rd, lb1_rd;

   assign lb_addr = in_line ? col_eff[AW-1:0] : '0;
   assign lb0_rd  = lb0[lb_addr];
   assign lb1_rd  = lb1[lb_addr];

   always_ff @(posedge clk) begin
      if (in_line) begin
         lb0[lb_addr] <= per_data;
         lb1[lb_addr] <= lb0_rd;
      end
   end

   // New window column per channel: [0]=row r-2, [1]=row r-1, [2]=row r,
   // with rows above the frame replicated from row 0.
   logic [DW-1:0] new_col [CHANNELS][3];

   always_comb begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
         new_col[ch][2] = per_data[ch*DW +: DW];
         if (row_eff == '0) begin
            new_col[ch][0] = per_data[ch*DW +: DW];
            new_col[ch][1] = per_data[ch*DW +: DW];
         end else if (row_eff == RW'(1)) begin
            new_col[ch][0] = lb0_rd[ch*DW +: DW];
            new_col[ch][1] = lb0_rd[ch*DW +: DW];
         end else begin
            new_col[ch][0] = lb1_rd[ch*DW +: DW];
            new_col[ch][1] = lb0_rd[ch*DW +: DW];
         end
      end
   end

   // ------------------------------------------------------------------
   // Valid pipeline. Each data stage loads only when its own valid bit
   // is set, which keeps the latency fixed across per_de gaps while
   // holding the stage contents otherwise.
   // ------------------------------------------------------------------
   logic [2:0] vs_p, de_p;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_p <= '0;
         de_p <= '0;
      end else begin
         vs_p <= {vs_p[1:0], per_vs};
         de_p <= {de_p[1:0], per_de};
      end
   end

   assign post_vs = vs_p[2];
   assign post_de = de_p[2];

   // Stage 1: window capture. win[ch][r][0] is the oldest column (c-2);
   // the first pixel of a line fills all three columns (left replicate).
   logic [DW-1:0] win [CHANNELS][3][3];
   logic [PW-1:0] s1_pix;
   logic          s1_filt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_pix  <= '0;
         s1_filt <= 1'b0;
         for (int ch = 0; ch < CHANNELS; ch++)
            for (int r = 0; r < 3; r++)
               for (int k = 0; k < 3; k++)
                  win[ch][r][k] <= '0;
      end else if (per_de) begin
         s1_pix  <= per_data;
         s1_filt <= fen_eff & in_line;
         if (in_line) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
               for (int r = 0; r < 3; r++) begin
                  if (col_eff == '0) begin
                     win[ch][r][0] <= new_col[ch][r];
                     win[ch][r][1] <= new_col[ch][r];
                     win[ch][r][2] <= new_col[ch][r];
                  end else begin
                     win[ch][r][0] <= win[ch][r][1];
                     win[ch][r][1] <= win[ch][r][2];
                     win[ch][r][2] <= new_col[ch][r];
                  end
               end
            end
         end
      end
   end

   // Stage 2: row sums.
   logic [RSW-1:0] rsum [CHANNELS][3];
   logic [PW-1:0]  s2_pix;
   logic           s2_filt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_pix  <= '0;
         s2_filt <= 1'b0;
         for (int ch = 0; ch < CHANNELS; ch++)
            for (int r = 0; r < 3; r++)
               rsum[ch][r] <= '0;
      end else if (de_p[0]) begin
         s2_pix  <= s1_pix;
         s2_filt <= s1_filt;
         for (int ch = 0; ch < CHANNELS; ch++)
            for (int r = 0; r < 3; r++)
               rsum[ch][r] <= RSW'(win[ch][r][0]) + RSW'(win[ch][r][1]) + RSW'(win[ch][r][2]);
      end
   end

   // Stage 3: total and divide by 9. The quotient never exceeds 2^DW-1,
   // even with the rounding bias, so the narrowing cast is lossless.
   logic [PW-1:0] filt_pix;
   logic [SW-1:0] tot;

   always_comb begin
      filt_pix = '0;
      tot      = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         tot = SW'(rsum[ch][0]) + SW'(rsum[ch][1]) + SW'(rsum[ch][2]);
         filt_pix[ch*DW +: DW] = DW'((tot + SW'(RND)) / SW'(9));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         post_data <= '0;
      else if (de_p[1])
         post_data <= s2_filt ? filt_pix : s2_pix;
   end

endmodule

// File: tb/tb_mean_filter.sv
// Purpose : self-checking bench for mean_filter on an 8x4 frame, random and directed frames.
// Latency : expects every output 3 clk after the matching input.
// Backpres: none; the bench drives one input sample per clock.
module tb_mean_filter;

   localparam int HD  = 8;
   localparam int VD  = 4;
   localparam int DWT = 8;
   localparam int CH  = 3;
   localparam int PW  = CH * DWT;
`ifdef MEAN_FILTER_ROUND_EN
   localparam int RND = 4;
`else
   localparam int RND = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          per_vs;
   logic          per_de;
   logic [PW-1:0] per_data;
   logic          post_vs;
   logic          post_de;
   logic [PW-1:0] post_data;

   mean_filter #(
      .IMG_HDISP(HD),
      .IMG_VDISP(VD),
      .DW(DWT),
      .CHANNELS(CH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .per_vs(per_vs),
      .per_de(per_de),
      .per_data(per_data),
      .post_vs(post_vs),
      .post_de(post_de),
      .post_data(post_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: pixels are stored into a frame image at the
   // position given by the counter rules; the mean is computed from the
   // image with clamped indices.
   // ------------------------------------------------------------------
   typedef struct packed {
      logic          vs;
      logic          de;
      logic [PW-1:0] d;
   } exp_t;

   exp_t          exp_q[$];
   logic [PW-1:0] img [0:VD][0:HD-1];
   logic          m_prev_vs, m_prev_de, m_fen;
   int            m_col, m_row;
   logic [PW-1:0] m_last;
   logic          mon_en = 1'b0;

   function automatic logic [PW-1:0] model_mean(input int r, input int c);
      logic [PW-1:0] o;
      int s, rr, cc;
      o = '0;
      for (int ch = 0; ch < CH; ch++) begin
         s = 0;
         for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
               rr = (r - dr < 0) ? 0 : r - dr;
               cc = (c - dc < 0) ? 0 : c - dc;
               s += int'(img[rr][cc][ch*DWT +: DWT]);
            end
         end
         o[ch*DWT +: DWT] = DWT'((s + RND) / 9);
      end
      return o;
   endfunction

   task automatic model_reset();
      exp_t z;
      m_prev_vs = 1'b1;   // reset mid-frame must not look like a frame start
      m_prev_de = 1'b0;
      m_fen     = 1'b0;
      m_col     = 0;
      m_row     = 0;
      m_last    = '0;
      exp_q.delete();
      z = '0;
      repeat (3) exp_q.push_back(z);   // pipeline comes out of reset empty
   endtask

   task automatic drive_cycle(input logic vs, input logic de, input logic [PW-1:0] d);
      exp_t          e;
      logic [PW-1:0] od;
      logic          rise;
      per_vs   = vs;
      per_de   = de;
      per_data = d;
      rise = vs && !m_prev_vs;
      if (rise) begin
         m_col = 0;
         m_row = 0;
         m_fen = en;
      end
      od = m_last;
      if (de) begin
         if (m_col < HD) begin
            img[m_row][m_col] = d;
            od = m_fen ? model_mean(m_row, m_col) : d;
            m_col++;
         end else begin
            od = d;
         end
      end else if (m_prev_de && !rise) begin
         m_col = 0;
         if (m_row < VD) m_row++;
      end
      m_last    = od;
      m_prev_vs = vs;
      m_prev_de = de;
      e.vs = vs;
      e.de = de;
      e.d  = od;
      exp_q.push_back(e);
   endtask

   task automatic tick(input logic vs, input logic de, input logic [PW-1:0] d);
      @(posedge clk);
      #1;
      drive_cycle(vs, de, d);
   endtask

   // Output e was driven 3 clocks before the current negedge.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en) begin
         while (exp_q.size() > 3) begin
            e = exp_q.pop_front();
            chk_eq("post_vs", post_vs, e.vs);
            chk_eq("post_de", post_de, e.de);
            chk_eq("post_data", post_data, e.d);
         end
      end
   end

   // kind: 0 random, 1 flat 100, 2 impulse 90, 3 ramp, 4 single 13, 5 single 14
   function automatic logic [PW-1:0] pix(input int kind, input int r, input int c);
      logic [PW-1:0] p;
      p = '0;
      case (kind)
         0: p = PW'($urandom);
         1: for (int ch = 0; ch < CH; ch++) p[ch*DWT +: DWT] = 8'd100;
         2: if (r == 2 && c == 2) p[7:0] = 8'd90;
         3: for (int ch = 0; ch < CH; ch++) p[ch*DWT +: DWT] = DWT'(r * 20 + c * 9 + ch * 50);
         4: if (r == 2 && c == 2) p[7:0] = 8'd13;
         5: if (r == 2 && c == 2) p[7:0] = 8'd14;
         default: p = '0;
      endcase
      return p;
   endfunction

   // lead = cycles of per_vs high before the first pixel (0: same cycle);
   // en_line switches en on before that line; long_line carries HD+2 pixels.
   task automatic send_frame(input int kind, input int lead, input int en_line, input int long_line);
      int n;
      repeat (3) tick(1'b0, 1'b0, '0);
      repeat (lead) tick(1'b1, 1'b0, '0);
      for (int r = 0; r < VD; r++) begin
         if (r == en_line) en = 1'b1;
         n = (r == long_line) ? HD + 2 : HD;
         for (int c = 0; c < n; c++) tick(1'b1, 1'b1, pix(kind, r, c));
         repeat (1 + $urandom_range(0, 3)) tick(1'b1, 1'b0, '0);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      en       = 1'b0;
      per_vs   = 1'b0;
      per_de   = 1'b0;
      per_data = '0;
      #12;
      chk_eq("reset_post_vs", post_vs, 1'b0);
      chk_eq("reset_post_de", post_de, 1'b0);
      chk_eq("reset_post_data", post_data, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      drive_cycle(1'b0, 1'b0, '0);
      mon_en = 1'b1;

      // directed frames
      en = 1'b1;
      send_frame(1, 2, -1, -1);   // flat 100
      send_frame(2, 1, -1, -1);   // impulse
      send_frame(4, 1, -1, -1);   // window sum 13
      send_frame(5, 1, -1, -1);   // window sum 14
      en = 1'b0;
      send_frame(0, 2, 2, -1);    // en raised mid-frame: whole frame bypassed
      send_frame(0, 0, -1, -1);   // filtered; frame start coincides with first pixel

      // irregular per_de (1 high, 2 low) with a ramp
      repeat (3) tick(1'b0, 1'b0, '0);
      tick(1'b1, 1'b0, '0);
      for (int i = 0; i < VD; i++) begin
         tick(1'b1, 1'b1, pix(3, i, 0));
         tick(1'b1, 1'b0, '0);
         tick(1'b1, 1'b0, '0);
      end

      // over-long line followed by a normal line
      send_frame(3, 1, -1, 1);

      // reset during active per_de
      repeat (3) tick(1'b0, 1'b0, '0);
      tick(1'b1, 1'b0, '0);
      for (int c = 0; c < HD; c++) tick(1'b1, 1'b1, pix(3, 0, c));
      tick(1'b1, 1'b0, '0);
      for (int c = 0; c < 4; c++) tick(1'b1, 1'b1, pix(3, 1, c));
      @(posedge clk);
      #1;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk_eq("midrst_post_vs", post_vs, 1'b0);
      chk_eq("midrst_post_de", post_de, 1'b0);
      chk_eq("midrst_post_data", post_data, '0);
      repeat (2) @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      drive_cycle(1'b1, 1'b1, pix(3, 1, 4));
      mon_en = 1'b1;
      for (int c = 5; c < HD; c++) tick(1'b1, 1'b1, pix(3, 1, c));
      tick(1'b1, 1'b0, '0);
      for (int r = 2; r < VD; r++) begin
         for (int c = 0; c < HD; c++) tick(1'b1, 1'b1, pix(3, r, c));
         tick(1'b1, 1'b0, '0);
      end
      send_frame(3, 1, -1, -1);   // next frame filtered again

      // random frames
      for (int f = 0; f < 8; f++) begin
         en = 1'($urandom_range(0, 1));
         send_frame(0, $urandom_range(0, 2), -1, -1);
      end

      repeat (6) tick(1'b0, 1'b0, '0);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
